imm_encoder: RTL

Pipelined immediate encoder for the single-cycle core's test and instruction-generation path: takes a 32-bit signed immediate plus an immediate class and produces the 25-bit instruction field `inst[31:7]` that the core's immediate extender decodes back. It range- and alignment-checks each request and flags immediates that cannot be represented. A valid/ready pipeline with two stages sits between an instruction generator (upstream) and an instruction assembler or memory writer (downstream).

---
 rtl/imm_pkg.sv | 32 +++
 rtl/imm_pack.sv | 47 ++++
 rtl/imm_encoder.sv | 102 ++++++++++
 3 files changed

// File: rtl/imm_pkg.sv
// Shared immediate-class encoding and legal ranges for the encoder and the core's extender.
package imm_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_class_e;

    localparam int IMM_W   = 32;
    localparam int FIELD_W = 25;
    localparam int CNT_W   = 16;

    localparam logic signed [IMM_W-1:0] I_MIN = -32'sd2048;
    localparam logic signed [IMM_W-1:0] I_MAX =  32'sd2047;
    localparam logic signed [IMM_W-1:0] S_MIN = -32'sd2048;
    localparam logic signed [IMM_W-1:0] S_MAX =  32'sd2047;
    localparam logic signed [IMM_W-1:0] B_MIN = -32'sd4096;
    localparam logic signed [IMM_W-1:0] B_MAX =  32'sd4094;
    localparam logic signed [IMM_W-1:0] J_MIN = -32'sd1048576;
    localparam logic signed [IMM_W-1:0] J_MAX =  32'sd1048574;

    function automatic logic in_range(
        input logic signed [IMM_W-1:0] v,
        input logic signed [IMM_W-1:0] lo,
        input logic signed [IMM_W-1:0] hi
    );
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational class-to-field packer with range/alignment check; illegal requests yield a zero field.
module imm_pack
    import imm_pkg::*;
(
    input  imm_class_e               i_src,
    input  logic signed [IMM_W-1:0]  i_imm,
    output logic [FIELD_W-1:0]       o_value,
    output logic                     o_err
);

    logic [FIELD_W-1:0] w_field;
    logic               w_legal;

    always_comb begin
        w_field = '0;
        w_legal = 1'b0;
        unique case (i_src)
            IMM_I: begin
                w_field[24:13] = i_imm[11:0];
                w_legal        = in_range(i_imm, I_MIN, I_MAX);
            end
            IMM_S: begin
                w_field[24:18] = i_imm[11:5];
                w_field[4:0]   = i_imm[4:0];
                w_legal        = in_range(i_imm, S_MIN, S_MAX);
            end
            // Branch and jump offsets are halfword aligned, so bit 0 is never encoded.
            IMM_B: begin
                w_field[24]    = i_imm[12];
                w_field[23:18] = i_imm[10:5];
                w_field[4:1]   = i_imm[4:1];
                w_field[0]     = i_imm[11];
                w_legal        = in_range(i_imm, B_MIN, B_MAX) && !i_imm[0];
            end
            IMM_J: begin
                w_field[24]    = i_imm[20];
                w_field[23:14] = i_imm[10:1];
                w_field[13]    = i_imm[11];
                w_field[12:5]  = i_imm[19:12];
                w_legal        = in_range(i_imm, J_MIN, J_MAX) && !i_imm[0];
            end
        endcase
        o_err   = !w_legal;
        o_value = w_legal ? w_field : '0;
    end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready immediate encoder producing inst[31:7] with error flag and saturating result counters.
module imm_encoder
    import imm_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           immSrc,
    input  logic [IMM_W-1:0]     immExt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FIELD_W-1:0]   immValue,
    output logic                 out_err,
    output logic [CNT_W-1:0]     enc_count,
    output logic [CNT_W-1:0]     err_count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    logic                      r_vld_p1;
    imm_class_e                r_src_p1;
    logic signed [IMM_W-1:0]   r_imm_p1;

    logic                      r_vld_p2;
    logic [FIELD_W-1:0]        r_val_p2;
    logic                      r_err_p2;

    logic [CNT_W-1:0]          r_enc_cnt;
    logic [CNT_W-1:0]          r_err_cnt;

    logic [FIELD_W-1:0]        w_val;
    logic                      w_err;
    logic                      w_s2_load;
    logic                      w_out_hs;

    // No skid buffer: a full pipe accepts only when the output drains this cycle.
    assign w_s2_load = !r_vld_p2 || out_ready;
    assign in_ready  = !r_vld_p1 || w_s2_load;
    assign w_out_hs  = r_vld_p2 && out_ready;

    // ---- stage 1: capture request ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p1 <= 1'b0;
        end else if (in_ready) begin
            r_vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            r_src_p1 <= imm_class_e'(immSrc);
            r_imm_p1 <= $signed(immExt);
        end
    end

    imm_pack u_pack (
        .i_src   (r_src_p1),
        .i_imm   (r_imm_p1),
        .o_value (w_val),
        .o_err   (w_err)
    );

    // ---- stage 2: packed field and error flag ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p2 <= 1'b0;
            r_val_p2 <= '0;
            r_err_p2 <= 1'b0;
        end else if (w_s2_load) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_val_p2 <= w_val;
                r_err_p2 <= w_err;
            end
        end
    end

    // ---- result counters: output handshake only ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_enc_cnt <= '0;
            r_err_cnt <= '0;
        end else if (w_out_hs) begin
            if (r_err_p2) begin
                r_err_cnt <= sat_inc(r_err_cnt);
            end else begin
                r_enc_cnt <= sat_inc(r_enc_cnt);
            end
        end
    end

    assign out_valid = r_vld_p2;
    assign immValue  = r_val_p2;
    assign out_err   = r_err_p2;
    assign enc_count = r_enc_cnt;
    assign err_count = r_err_cnt;

endmodule
